// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared drive types, PWM range and speed helpers for the motor driver
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } drive_state_t;

  localparam int PWM_MAX = 511;

  typedef logic signed [9:0] speed_t;
  typedef logic [8:0]        mag_t;

  // -512 has no positive twin in 9 bits, so it is pulled in to -511
  function automatic speed_t sat_speed(input speed_t s);
    return (s == speed_t'(10'h200)) ? speed_t'(10'h201) : s;
  endfunction

  function automatic mag_t speed_mag(input speed_t s);
    logic [9:0] n;
    n = -s;
    return s[9] ? n[8:0] : s[8:0];
  endfunction

endpackage

// File: rtl/wheel_ramp.sv
// rtl/wheel_ramp.sv - per-wheel slew-limited magnitude, direction and PWM compare
// Optional MOTOR_DEADBAND_EN: magnitudes below DEADBAND are skipped.
module wheel_ramp
  import motor_pkg::*;
#(
  parameter int RAMP_STEP = 8,
  parameter int DEADBAND  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       step,
  input  speed_t     target,
  input  logic [8:0] count_next,
  output logic       pwm,
  output logic       dir,
  output speed_t     applied
);

  localparam logic [9:0] STEP = 10'(RAMP_STEP);

  mag_t       mag_q, mag_n, tgt_mag, goal;
  logic       dir_n, tgt_fwd;
  logic [9:0] cur, want, nxt;

  always_comb begin
    tgt_fwd = !target[9];
    tgt_mag = speed_mag(target);
`ifdef MOTOR_DEADBAND_EN
    if (tgt_mag < mag_t'(DEADBAND)) tgt_mag = '0;
`endif
    // an opposing target first drains the wheel to zero; direction only turns at rest
    goal = (mag_q == '0 || tgt_fwd == dir) ? tgt_mag : '0;
    cur  = {1'b0, mag_q};
    want = {1'b0, goal};
    if (cur < want) nxt = ((want - cur) > STEP) ? cur + STEP : want;
    else            nxt = ((cur - want) > STEP) ? cur - STEP : want;
`ifdef MOTOR_DEADBAND_EN
    if (nxt != '0 && nxt < 10'(DEADBAND)) nxt = (nxt > cur) ? 10'(DEADBAND) : '0;
`endif
    mag_n = mag_q;
    dir_n = dir;
    if (clear) begin
      mag_n = '0;
    end else if (step) begin
      mag_n = nxt[8:0];
      if (mag_q == '0) dir_n = tgt_fwd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag_q <= '0;
      dir   <= 1'b0;
      pwm   <= 1'b0;
    end else begin
      mag_q <= mag_n;
      dir   <= dir_n;
      pwm   <= !clear && (count_next < mag_n);
    end
  end

  assign applied = dir ? $signed({1'b0, mag_q}) : -$signed({1'b0, mag_q});

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - two-channel H-bridge PWM driver with ramping, safe reversal and watchdog
// Optional MOTOR_DEADBAND_EN: enables the stall-region skip in both wheel ramps.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE        = 4,
  parameter int RAMP_STEP       = 8,
  parameter int TIMEOUT_PERIODS = 64,
  parameter int DEADBAND        = 16
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   enable,
  input  logic   cmd_valid,
  input  speed_t target_speed_left,
  input  speed_t target_speed_right,
  output logic   pwm_left,
  output logic   pwm_right,
  output logic   dir_left,
  output logic   dir_right,
  output logic   brake,
  output speed_t applied_left,
  output speed_t applied_right,
  output logic   fault,
  output logic   period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WW = $clog2(TIMEOUT_PERIODS + 1);

  logic [PW-1:0] presc_q;
  logic [8:0]    count_q, count_n;
  logic          tick, boundary, wd_trip, clear, step;
  logic [WW-1:0] wd_q;
  drive_state_t  state_q, state_n;
  speed_t        tgt_left_q, tgt_right_q, eff_left, eff_right;

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign boundary = tick && (count_q == 9'(PWM_MAX - 1));
  assign count_n  = !tick ? count_q : (boundary ? 9'd0 : count_q + 9'd1);

  // a command landing on the boundary cycle is used by that same boundary
  assign eff_left  = cmd_valid ? sat_speed(target_speed_left)  : tgt_left_q;
  assign eff_right = cmd_valid ? sat_speed(target_speed_right) : tgt_right_q;

  assign wd_trip = boundary && !cmd_valid && (wd_q == WW'(TIMEOUT_PERIODS - 1));

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (boundary && enable && !fault) state_n = RUN;
      RUN:     if (!enable) state_n = IDLE;
               else if (wd_trip) state_n = FAULT;
      FAULT:   if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign clear = (state_n != RUN);
  assign step  = boundary && (state_q == RUN) && (state_n == RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      count_q      <= '0;
      tgt_left_q   <= '0;
      tgt_right_q  <= '0;
      state_q      <= IDLE;
      fault        <= 1'b0;
      brake        <= 1'b1;
      period_start <= 1'b0;
      wd_q         <= '0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + PW'(1);
      count_q      <= count_n;
      if (cmd_valid) begin
        tgt_left_q  <= eff_left;
        tgt_right_q <= eff_right;
      end
      state_q      <= state_n;
      fault        <= (state_n == FAULT);
      brake        <= clear;
      period_start <= boundary;
      if (state_q != RUN || state_n != RUN || cmd_valid) wd_q <= '0;
      else if (boundary)                                 wd_q <= wd_q + WW'(1);
    end
  end

  wheel_ramp #(.RAMP_STEP(RAMP_STEP), .DEADBAND(DEADBAND)) u_wheel_left (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .step       (step),
    .target     (eff_left),
    .count_next (count_n),
    .pwm        (pwm_left),
    .dir        (dir_left),
    .applied    (applied_left)
  );

  wheel_ramp #(.RAMP_STEP(RAMP_STEP), .DEADBAND(DEADBAND)) u_wheel_right (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .step       (step),
    .target     (eff_right),
    .count_next (count_n),
    .pwm        (pwm_right),
    .dir        (dir_right),
    .applied    (applied_right)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - scoreboard bench for motor_pwm_driver (PRESCALE=1 for short periods)
module tb_motor_pwm_driver;
  import motor_pkg::*;

  logic   clock = 1'b0, reset_n = 1'b0, enable = 1'b0, cmd_valid = 1'b0;
  speed_t tsl = '0, tsr = '0;
  logic   pwm_left, pwm_right, dir_left, dir_right, brake, fault, period_start;
  speed_t applied_left, applied_right;

  int checks = 0, passes = 0;

  typedef struct {
    int l; int r; int dl; int dr; int brk; int flt;
  } exp_t;
  exp_t sbq[$];

  motor_pwm_driver #(.PRESCALE(1)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .enable             (enable),
    .cmd_valid          (cmd_valid),
    .target_speed_left  (tsl),
    .target_speed_right (tsr),
    .pwm_left           (pwm_left),
    .pwm_right          (pwm_right),
    .dir_left           (dir_left),
    .dir_right          (dir_right),
    .brake              (brake),
    .applied_left       (applied_left),
    .applied_right      (applied_right),
    .fault              (fault),
    .period_start       (period_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input int l, input int r, input int dl, input int dr, input int brk, input int flt);
    exp_t e;
    e.l = l; e.r = r; e.dl = dl; e.dr = dr; e.brk = brk; e.flt = flt;
    sbq.push_back(e);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge clock) begin
    if (reset_n && period_start && sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("applied_left", int'(applied_left), e.l);
      check("applied_right", int'(applied_right), e.r);
      check("dir_left", int'(dir_left), e.dl);
      check("dir_right", int'(dir_right), e.dr);
      check("brake", int'(brake), e.brk);
      check("fault", int'(fault), e.flt);
    end
  end

  task automatic drain(input int periods);
    int n = 0;
    while (sbq.size() > 0 && n < periods * 520) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() > 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic wait_period();
    int n = 0;
    @(negedge clock);
    while (!period_start && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (!period_start) check("period_timeout", 0, 1);
  endtask

  task automatic send(input int l, input int r);
    @(negedge clock);
    tsl = speed_t'(l);
    tsr = speed_t'(r);
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cl, cr;
    @(negedge clock);
    check("rst_brake", int'(brake), 1);
    check("rst_pwm_left", int'(pwm_left), 0);
    check("rst_pwm_right", int'(pwm_right), 0);
    check("rst_dir_left", int'(dir_left), 0);
    check("rst_applied_left", int'(applied_left), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_period_start", int'(period_start), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // ramp up: RUN after one boundary, then 8,16,...,96,100
    enable = 1'b1;
    send(100, 100);
    push(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 13; k++) push(imin(8 * k, 100), imin(8 * k, 100), 1, 1, 0, 0);
    drain(16);
    wait_period();
    cl = 0; cr = 0;
    for (int i = 0; i < 511; i++) begin
      cl += int'(pwm_left);
      cr += int'(pwm_right);
      @(negedge clock);
    end
    check("duty_left_100", cl, 100);
    check("duty_right_100", cr, 100);

    // settle left at +40, then reverse through zero to -40
    send(40, 100);
    for (int k = 1; k <= 8; k++) push((100 - 8 * k > 40) ? 100 - 8 * k : 40, 100, 1, 1, 0, 0);
    drain(10);
    send(-40, 100);
    for (int k = 1; k <= 5; k++) push(40 - 8 * k, 100, 1, 1, 0, 0);
    for (int k = 6; k <= 10; k++) push(-8 * (k - 5), 100, 0, 1, 0, 0);
    drain(12);

    // watchdog: last command at +200, fault on the 64th boundary after it
    send(-40, 200);
    for (int k = 1; k <= 63; k++) push(-40, imin(100 + 8 * k, 200), 0, 1, 0, 0);
    push(0, 0, 0, 1, 1, 1);
    drain(66);
    send(100, 100);
    push(0, 0, 0, 1, 1, 1);
    push(0, 0, 0, 1, 1, 1);
    drain(3);

    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("idle_brake", int'(brake), 1);
    check("idle_fault_clear", int'(fault), 0);
    check("idle_applied_right", int'(applied_right), 0);
    check("idle_pwm_right", int'(pwm_right), 0);

    // extremes: -512 saturates to -511, +511 held; refresh before the watchdog expires
    enable = 1'b1;
    send(-512, 511);
    push(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 40; k++) push(-imin(8 * k, 511), imin(8 * k, 511), 0, 1, 0, 0);
    drain(42);
    send(-512, 511);
    for (int k = 41; k <= 64; k++) push(-imin(8 * k, 511), imin(8 * k, 511), 0, 1, 0, 0);
    drain(26);
    cl = 0;
    for (int i = 0; i < 511; i++) begin
      cl += int'(pwm_left && pwm_right);
      @(negedge clock);
    end
    check("duty_full_scale", cl, 511);

    // async reset at count 250
    wait_period();
    repeat (250) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_brake", int'(brake), 1);
    check("async_pwm_left", int'(pwm_left), 0);
    check("async_applied_left", int'(applied_left), 0);
    check("async_applied_right", int'(applied_right), 0);
    check("async_dir_right", int'(dir_right), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("post_reset_idle_brake", int'(brake), 1);
    push(0, 0, 0, 0, 0, 0);
    drain(3);

`ifdef MOTOR_DEADBAND_EN
    send(10, 10);
    push(0, 0, 1, 1, 0, 0);
    push(0, 0, 1, 1, 0, 0);
    drain(3);
    send(50, 50);
    push(16, 16, 1, 1, 0, 0);
    push(24, 24, 1, 1, 0, 0);
    push(32, 32, 1, 1, 0, 0);
    push(40, 40, 1, 1, 0, 0);
    push(48, 48, 1, 1, 0, 0);
    push(50, 50, 1, 1, 0, 0);
    drain(8);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
